// File: rtl/router_pkg.sv
// Shared definitions for the router output-port drain stage: header field layout
// and parser state encoding.
package router_pkg;

  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int LEN_W    = 6;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;

  typedef enum logic [1:0] {
    ST_HDR = 2'd0,
    ST_PAY = 2'd1,
    ST_PAR = 2'd2
  } parse_state_e;

  function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] hdr);
    return hdr[LEN_MSB:LEN_LSB];
  endfunction

endpackage

// File: rtl/router_out_buf.sv
// Small elastic FIFO between the router FIFO read port and the output stream.
// Combinational head; simultaneous push and pop keep occupancy unchanged.
module router_out_buf #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     occ
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && (occ_q != FULL_OCC);
    do_pop   = pop && (occ_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is data only; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  assign dout  = mem[rd_ptr_q];
  assign empty = (occ_q == '0);
  assign occ   = occ_q;

endmodule

// File: rtl/router_out_port.sv
// Drains one router output channel into a valid/ready byte stream tagged with
// sop/eop/err, with per-port packet and parity-error counters.
module router_out_port
  import router_pkg::*;
#(
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vld_out,
  input  logic [7:0]       data_in,
  input  logic             soft_reset,
  output logic             read_enb,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_sop,
  output logic             m_eop,
  output logic             m_err,
  output logic             abort,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int OCC_W = $clog2(BUF_DEPTH) + 1;
  localparam int SUM_W = OCC_W + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             buf_empty;
  logic [OCC_W-1:0] buf_occ;
  logic [7:0]       head;
  logic             beat;
  logic             flush_done;
  logic             parity_err;
  logic [SUM_W-1:0] fill;

  logic             rd_inflight_q, rd_inflight_d;
  logic             abort_pend_q, abort_pend_d;
  logic             abort_q, abort_d;
  parse_state_e     state_q, state_d;
  logic [7:0]       acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  logic [CNT_W-1:0] err_q, err_d;

  router_out_buf #(
    .DEPTH (BUF_DEPTH),
    .W     (8)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (rd_inflight_q),
    .din   (data_in),
    .pop   (beat),
    .dout  (head),
    .empty (buf_empty),
    .occ   (buf_occ)
  );

  // Fetch control: count the byte still in flight so the buffer can never overflow.
  always_comb begin
    fill          = SUM_W'(buf_occ) + SUM_W'(rd_inflight_q);
    read_enb      = !reset && vld_out && !abort_pend_q && (fill < SUM_W'(BUF_DEPTH));
    rd_inflight_d = read_enb;
    flush_done    = abort_pend_q && buf_empty && !rd_inflight_q;
    abort_pend_d  = soft_reset || (abort_pend_q && !flush_done);
    abort_d       = flush_done && (state_q != ST_HDR);
  end

  assign m_valid    = !buf_empty;
  assign m_data     = head;
  assign beat       = m_valid && m_ready;
  assign parity_err = (acc_q != head);
  assign m_sop      = m_valid && (state_q == ST_HDR);
  assign m_eop      = m_valid && (state_q == ST_PAR);
  assign m_err      = m_eop && parity_err;

  // Parser advances only on accepted beats; a finished soft-reset flush forces HDR.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    pkt_d   = pkt_q;
    err_d   = err_q;
    if (flush_done) begin
      state_d = ST_HDR;
      acc_d   = '0;
    end else if (beat) begin
      case (state_q)
        ST_HDR: begin
          acc_d   = head;
          cnt_d   = hdr_len(head);
          state_d = (hdr_len(head) != '0) ? ST_PAY : ST_PAR;
        end
        ST_PAY: begin
          acc_d = acc_q ^ head;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = ST_PAR;
        end
        ST_PAR: begin
          pkt_d   = sat_inc(pkt_q);
          if (parity_err) err_d = sat_inc(err_q);
          state_d = ST_HDR;
        end
        default: state_d = ST_HDR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_inflight_q <= 1'b0;
      abort_pend_q  <= 1'b0;
      abort_q       <= 1'b0;
      state_q       <= ST_HDR;
      acc_q         <= '0;
      cnt_q         <= '0;
      pkt_q         <= '0;
      err_q         <= '0;
    end else begin
      rd_inflight_q <= rd_inflight_d;
      abort_pend_q  <= abort_pend_d;
      abort_q       <= abort_d;
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      pkt_q         <= pkt_d;
      err_q         <= err_d;
    end
  end

  assign abort     = abort_q;
  assign pkt_count = pkt_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_router_out_port.sv
// Directed bench for router_out_port with a behavioural router FIFO whose
// dataout is registered one cycle after read_enb.
module tb_router_out_port;

  localparam int BUF_DEPTH = 4;
  localparam int CNT_W     = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             soft_reset;
  logic             m_ready;
  logic             tb_flush;
  logic             vld_out;
  logic [7:0]       data_in;
  logic             read_enb;
  logic             m_valid;
  logic [7:0]       m_data;
  logic             m_sop, m_eop, m_err, abort;
  logic [CNT_W-1:0] pkt_count, err_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] src [0:255];
  int         wr_idx = 0;
  int         rd_idx = 0;

  logic [7:0] b_data [0:15];
  logic       b_sop  [0:15];
  logic       b_eop  [0:15];
  logic       b_err  [0:15];

  router_out_port #(
    .BUF_DEPTH (BUF_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vld_out    (vld_out),
    .data_in    (data_in),
    .soft_reset (soft_reset),
    .read_enb   (read_enb),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_sop      (m_sop),
    .m_eop      (m_eop),
    .m_err      (m_err),
    .abort      (abort),
    .pkt_count  (pkt_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  assign vld_out = (rd_idx != wr_idx);

  always @(posedge clk) begin
    if (soft_reset || tb_flush) begin
      rd_idx <= wr_idx;
    end else if (read_enb && (rd_idx != wr_idx)) begin
      data_in <= src[rd_idx];
      rd_idx  <= rd_idx + 1;
    end
  end

  task automatic load_pkt(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      src[wr_idx] = v[8*(n-1-i) +: 8];
      wr_idx = wr_idx + 1;
    end
  endtask

  // Samples at the current time first, then at each following negedge.
  task automatic collect(input int n, input int max_cyc);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < max_cyc) begin
      if (m_valid && m_ready) begin
        b_data[got] = m_data;
        b_sop[got]  = m_sop;
        b_eop[got]  = m_eop;
        b_err[got]  = m_err;
        got++;
      end
      if (got < n) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (got < n) begin
      checks++;
      failures++;
      $display("FAIL collect_timeout got=%0d beats, required %0d", got, n);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    soft_reset = 1'b0;
    m_ready    = 1'b0;
    tb_flush   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tb_flush = 1'b0;
    reset    = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (m_valid !== 1'b0)  begin failures++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
    checks++; if (read_enb !== 1'b0) begin failures++; $display("FAIL rst_read_enb got=%b exp=0", read_enb); end
    checks++; if (abort !== 1'b0)    begin failures++; $display("FAIL rst_abort got=%b exp=0", abort); end
    checks++; if (pkt_count !== '0)  begin failures++; $display("FAIL rst_pkt_count got=%0d exp=0", pkt_count); end
    checks++; if (err_count !== '0)  begin failures++; $display("FAIL rst_err_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_good_packet();
    logic [7:0] exp_d [5];
    exp_d = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
    do_reset();
    m_ready = 1'b1;
    load_pkt(64'h0C1122330C, 5);
    #1;
    collect(5, 40);
    for (int i = 0; i < 5; i++) begin
      checks++; if (b_data[i] !== exp_d[i]) begin failures++; $display("FAIL good_data[%0d] got=%h exp=%h", i, b_data[i], exp_d[i]); end
      checks++; if (b_sop[i] !== (i == 0)) begin failures++; $display("FAIL good_sop[%0d] got=%b exp=%b", i, b_sop[i], (i == 0)); end
      checks++; if (b_eop[i] !== (i == 4)) begin failures++; $display("FAIL good_eop[%0d] got=%b exp=%b", i, b_eop[i], (i == 4)); end
    end
    checks++; if (b_err[4] !== 1'b0) begin failures++; $display("FAIL good_err got=%b exp=0", b_err[4]); end
    repeat (3) @(negedge clk);
    checks++; if (pkt_count !== 16'd1) begin failures++; $display("FAIL good_pkt_count got=%0d exp=1", pkt_count); end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL good_err_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_bad_parity();
    do_reset();
    m_ready = 1'b1;
    load_pkt(64'h0C1122330D, 5);
    #1;
    collect(5, 40);
    checks++; if (b_data[4] !== 8'h0D) begin failures++; $display("FAIL bad_par_data got=%h exp=0d", b_data[4]); end
    checks++; if (b_eop[4] !== 1'b1)   begin failures++; $display("FAIL bad_par_eop got=%b exp=1", b_eop[4]); end
    checks++; if (b_err[4] !== 1'b1)   begin failures++; $display("FAIL bad_par_err got=%b exp=1", b_err[4]); end
    repeat (3) @(negedge clk);
    checks++; if (pkt_count !== 16'd1) begin failures++; $display("FAIL bad_par_pkt_count got=%0d exp=1", pkt_count); end
    checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL bad_par_err_count got=%0d exp=1", err_count); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d [8];
    int n_rd;
    exp_d = '{8'h18, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h1F};
    do_reset();
    m_ready = 1'b0;
    load_pkt(64'h180102030405061F, 8);
    #1;
    n_rd = 0;
    for (int i = 0; i < 10; i++) begin
      if (read_enb) n_rd++;
      @(negedge clk);
      #1;
    end
    checks++; if (n_rd !== BUF_DEPTH) begin failures++; $display("FAIL bp_read_pulses got=%0d exp=%0d", n_rd, BUF_DEPTH); end
    checks++; if (read_enb !== 1'b0)  begin failures++; $display("FAIL bp_read_enb_held got=%b exp=0", read_enb); end
    checks++; if (m_valid !== 1'b1)   begin failures++; $display("FAIL bp_m_valid got=%b exp=1", m_valid); end
    m_ready = 1'b1;
    #1;
    collect(8, 40);
    for (int i = 0; i < 8; i++) begin
      checks++; if (b_data[i] !== exp_d[i]) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, b_data[i], exp_d[i]); end
    end
    checks++; if (b_err[7] !== 1'b0) begin failures++; $display("FAIL bp_err got=%b exp=0", b_err[7]); end
    repeat (3) @(negedge clk);
    checks++; if (pkt_count !== 16'd1) begin failures++; $display("FAIL bp_pkt_count got=%0d exp=1", pkt_count); end
    checks++; if (m_valid !== 1'b0)    begin failures++; $display("FAIL bp_no_extra got=%b exp=0", m_valid); end
  endtask

  task automatic test_zero_len();
    do_reset();
    m_ready = 1'b1;
    load_pkt(64'h0101, 2);
    #1;
    collect(2, 30);
    checks++; if (b_data[0] !== 8'h01) begin failures++; $display("FAIL zl_hdr got=%h exp=01", b_data[0]); end
    checks++; if (b_sop[0] !== 1'b1 || b_eop[0] !== 1'b0) begin failures++; $display("FAIL zl_tags0 got=sop%b eop%b exp=sop1 eop0", b_sop[0], b_eop[0]); end
    checks++; if (b_sop[1] !== 1'b0 || b_eop[1] !== 1'b1) begin failures++; $display("FAIL zl_tags1 got=sop%b eop%b exp=sop0 eop1", b_sop[1], b_eop[1]); end
    checks++; if (b_err[1] !== 1'b0) begin failures++; $display("FAIL zl_err got=%b exp=0", b_err[1]); end
    repeat (3) @(negedge clk);
    checks++; if (pkt_count !== 16'd1) begin failures++; $display("FAIL zl_pkt_count got=%0d exp=1", pkt_count); end
  endtask

  task automatic test_soft_reset();
    int n_ab;
    do_reset();
    m_ready = 1'b0;
    load_pkt(64'h14AABB, 3);
    repeat (6) @(negedge clk);
    soft_reset = 1'b1;
    @(negedge clk);
    soft_reset = 1'b0;
    m_ready    = 1'b1;
    #1;
    collect(3, 30);
    checks++; if (b_data[0] !== 8'h14 || b_data[1] !== 8'hAA || b_data[2] !== 8'hBB) begin
      failures++; $display("FAIL sr_drain got=%h %h %h exp=14 aa bb", b_data[0], b_data[1], b_data[2]);
    end
    n_ab = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (abort) n_ab++;
    end
    checks++; if (n_ab !== 1)         begin failures++; $display("FAIL sr_abort_pulses got=%0d exp=1", n_ab); end
    checks++; if (pkt_count !== '0)   begin failures++; $display("FAIL sr_pkt_count got=%0d exp=0", pkt_count); end
    load_pkt(64'h0801020B, 4);
    #1;
    collect(4, 30);
    checks++; if (b_data[0] !== 8'h08 || b_sop[0] !== 1'b1) begin failures++; $display("FAIL sr_next_hdr got=%h sop%b exp=08 sop1", b_data[0], b_sop[0]); end
    checks++; if (b_eop[3] !== 1'b1 || b_err[3] !== 1'b0)  begin failures++; $display("FAIL sr_next_par got=eop%b err%b exp=eop1 err0", b_eop[3], b_err[3]); end
    repeat (3) @(negedge clk);
    checks++; if (pkt_count !== 16'd1) begin failures++; $display("FAIL sr_next_pkt_count got=%0d exp=1", pkt_count); end
    soft_reset = 1'b1;
    @(negedge clk);
    soft_reset = 1'b0;
    n_ab = 0;
    for (int i = 0; i < 6; i++) begin
      if (abort) n_ab++;
      @(negedge clk);
    end
    checks++; if (n_ab !== 0)          begin failures++; $display("FAIL sr_idle_abort got=%0d exp=0", n_ab); end
    checks++; if (pkt_count !== 16'd1) begin failures++; $display("FAIL sr_idle_pkt_count got=%0d exp=1", pkt_count); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    m_ready = 1'b1;
    load_pkt(64'h0C1122330C, 5);
    #1;
    collect(5, 40);
    repeat (3) @(negedge clk);
    checks++; if (pkt_count !== 16'd1) begin failures++; $display("FAIL rmp_pre_pkt_count got=%0d exp=1", pkt_count); end
    load_pkt(64'h0C1122330C, 5);
    #1;
    collect(2, 30);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++; if (read_enb !== 1'b0)  begin failures++; $display("FAIL rmp_read_enb got=%b exp=0", read_enb); end
    checks++; if (m_valid !== 1'b0)   begin failures++; $display("FAIL rmp_m_valid got=%b exp=0", m_valid); end
    checks++; if (pkt_count !== '0)   begin failures++; $display("FAIL rmp_pkt_count got=%0d exp=0", pkt_count); end
    checks++; if (err_count !== '0)   begin failures++; $display("FAIL rmp_err_count got=%0d exp=0", err_count); end
    tb_flush = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tb_flush = 1'b0;
    reset    = 1'b0;
    load_pkt(64'h0101, 2);
    #1;
    collect(2, 30);
    checks++; if (b_data[0] !== 8'h01 || b_sop[0] !== 1'b1) begin failures++; $display("FAIL rmp_post_hdr got=%h sop%b exp=01 sop1", b_data[0], b_sop[0]); end
    checks++; if (b_eop[1] !== 1'b1 || b_err[1] !== 1'b0)  begin failures++; $display("FAIL rmp_post_par got=eop%b err%b exp=eop1 err0", b_eop[1], b_err[1]); end
    repeat (3) @(negedge clk);
    checks++; if (pkt_count !== 16'd1) begin failures++; $display("FAIL rmp_post_pkt_count got=%0d exp=1", pkt_count); end
  endtask

  initial begin
    reset      = 1'b1;
    soft_reset = 1'b0;
    m_ready    = 1'b0;
    tb_flush   = 1'b1;
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_backpressure();
    test_zero_len();
    test_soft_reset();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
